data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the MEM-stage memory interface: serves the mem_read/mem_write requests that the pipeline's memory stage initiates.
- Contains a word-addressed data store with a fixed, parameterised access latency.
- Drives a stall (freeze) signal back to the pipeline while an access is outstanding, and returns read data once the access completes.
- Sits beside mem_stage; its stall output feeds the hazard/freeze logic of all pipeline registers.

Parameters:
DATA_W, 32, data and address width in bits
DEPTH, 64, number of 32-bit words in the store
BASE_ADDR, 1024, byte address that maps to word 0
WAIT_CYCLES, 4, busy cycles per access; legal range 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets the block
mem_read  in  1  read request from the MEM stage
mem_write  in  1  write request from the MEM stage
addr  in  32  byte address (ALU result)
wdata  in  32  write data (val_Rm)
rdata  out  32  read data; holds its value until the next read completes
stall  out  1  high while a request is pending or busy; the pipeline freezes
rd_valid  out  1  one-cycle pulse when rdata is updated by a read
addr_err  out  1  one-cycle pulse in DONE if the access was out of range or had both requests asserted

Behaviour:
- Reset (rst==0 at a clock edge):
  - state<=IDLE, cnt<=0, rdata<=0, rd_valid<=0, addr_err<=0.
  - The store contents are NOT cleared.
  - Any in-flight access is discarded; a pending write is never performed.
  - stall is 0 during the reset cycle.
- Word index: idx = (addr - BASE_ADDR) >> 2, computed at 32 bits with wrap-around.
  - In range iff addr >= BASE_ADDR and idx < DEPTH.
  - addr[1:0] is ignored; accesses are aligned words only.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req = mem_read | mem_write.
  - stall = req (combinational, so the pipeline freezes in the same cycle as the request).
  - On req: latch addr, wdata and the write flag (wr = mem_write), set cnt<=WAIT_CYCLES-1, go to BUSY.
  - If mem_read and mem_write are both high, treat the request as a write and set a latched error flag.
- BUSY:
  - stall=1.
  - Inputs are ignored; the latched values are used.
  - If cnt!=0: cnt<=cnt-1. If cnt==0: perform the access and go to DONE.
  - Write, in range: store[idx]<=wdata.
  - Write, out of range: no store change, error flag set.
  - Read, in range: rdata<=store[idx].
  - Read, out of range: rdata<=0, error flag set.
  - On a read, rd_valid<=1 together with the rdata update.
- DONE:
  - stall=0; the pipeline registers advance at the end of this cycle.
  - rd_valid is high for this cycle only, on reads.
  - addr_err pulses high this cycle if the error flag is set.
  - Always go to IDLE next; the request lines are not sampled in DONE.
- Latency, measured from request cycle T0 in IDLE:
  - stall is high for cycles T0..T0+WAIT_CYCLES (WAIT_CYCLES+1 cycles).
  - DONE is cycle T0+WAIT_CYCLES+1, with rdata valid from that cycle.
- Back-to-back requests: a request present in the IDLE cycle after DONE starts a new access immediately. The minimum period is WAIT_CYCLES+2 cycles per access.
- No request in IDLE: stall=0 and every output holds.
- rdata is unchanged by writes and by idle cycles.
- Reset asserted while in BUSY or DONE: the block returns to IDLE on that edge and the store is unmodified by the aborted access.

Test Plan:
1. Write then read, WAIT_CYCLES=4:
   - Write addr=1024, wdata=0xDEADBEEF: stall high for 5 cycles, store[0]=0xDEADBEEF.
   - Then read addr=1024: rd_valid pulses in cycle T0+5 with rdata=0xDEADBEEF.
2. Address mapping:
   - Write 0x11 to addr 1028 and 0x22 to addr 1276 (idx 63).
   - Read back addr 1028 -> 0x11, addr 1276 -> 0x22; addr 1030 also returns 0x11 because bits [1:0] are ignored.
3. Out of range:
   - Read addr=1020 -> rdata=0, addr_err pulse.
   - Write addr=1280 -> no store change (store[0..63] unchanged), addr_err pulse.
4. Mid-access reset:
   - Start a write of 0x55 to addr 1032, assert rst low in BUSY cycle 2.
   - Required: next cycle state IDLE, stall=0, store[2] keeps its old value, rdata=0.
5. Back-to-back and input changes:
   - Hold mem_read=1 with addr changing every cycle during BUSY: the data returned is from the addr latched at T0.
   - A second read issued the cycle after DONE starts at T0+6 and completes at T0+11.
6. Both requests asserted:
   - mem_read=mem_write=1, addr=1024, wdata=0x7: the access is performed as a write and addr_err pulses in DONE.
   - A subsequent read of addr 1024 returns 0x7.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder side of the MEM-stage memory interface. Holds a word-addressed
//   data store with a fixed access latency and freezes the pipeline through
//   `stall` while an access is outstanding.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active low
//     mem_read   read request from the MEM stage
//     mem_write  write request from the MEM stage
//     addr       byte address (ALU result)
//     wdata      write data
//     rdata      read data; held until the next read completes
//     stall      high while a request is pending or busy
//     rd_valid   one-cycle pulse when rdata is updated by a read
//     addr_err   one-cycle pulse in DONE for an out-of-range access or for
//                a request with both mem_read and mem_write asserted
module data_mem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              rd_valid,
    output logic              addr_err
);

    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] BASE     = DATA_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] SPAN     = DATA_W'(DEPTH * 4);
    localparam logic [3:0]        CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              req;
    logic              access;
    logic [DATA_W-1:0] offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign req    = mem_read | mem_write;
    assign access = (state_q == BUSY) && (cnt_q == 4'd0);

    // (offset >> 2) < DEPTH is the same test as offset < 4*DEPTH; comparing
    // the full byte offset keeps every bit of the subtraction in use.
    assign offset   = addr_q - BASE;
    assign in_range = (addr_q >= BASE) && (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Store has no reset; a write aborted by reset must never land.
    always_ff @(posedge clk) begin
        if (rst && access && wr_q && in_range) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    // Both lines high is serviced as a write and flagged.
                    wr_d    = mem_write;
                    err_d   = mem_read & mem_write;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = DONE;
                    addr_err_d = err_q | ~in_range;
                    if (!wr_q) begin
                        rd_valid_d = 1'b1;
                        rdata_d    = in_range ? mem_q[idx] : '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // Combinational in IDLE so the pipeline freezes in the request cycle;
    // forced low while reset is asserted.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            stall = (state_q == BUSY) || ((state_q == IDLE) && req);
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        stall, rd_valid, addr_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: expected store contents and expected rdata register.
    logic [31:0] model [DEPTH];
    logic [31:0] model_rdata;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    data_mem_responder #(
        .DATA_W     (32),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (1024),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .rd_valid (rd_valid),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies the access rules to the reference state.
    function automatic void model_access(input bit rd, input bit wr,
                                         input logic [31:0] a, input logic [31:0] d,
                                         output bit exp_rv, output bit exp_err);
        bit          ok;
        int unsigned i;
        ok      = (a >= BASE) && (((a - BASE) / 4) < DEPTH);
        i       = (a - BASE) / 4;
        exp_err = !ok || (rd && wr);
        exp_rv  = rd && !wr;
        if (wr) begin
            if (ok) model[i] = d;
        end else if (rd) begin
            model_rdata = ok ? model[i] : 32'd0;
        end
    endfunction

    // Drives one request and observes the DUT until stall drops.
    // mode 0: inputs held; 1: mem_read held, addr/wdata randomised; 2: all random.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input int mode,
                             output bit done, output int nstall, output bit early,
                             output logic rv, output logic err, output logic [31:0] rdat);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        done = 0; nstall = 0; early = 0; rv = 0; err = 0; rdat = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall !== 1'b1) begin
                done = 1; rv = rd_valid; err = addr_err; rdat = rdata;
            end else begin
                nstall++;
                if (rd_valid !== 1'b0 || addr_err !== 1'b0) early = 1;
                step();
                if (mode == 1) begin
                    mem_read = 1'b1; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
                end else if (mode == 2) begin
                    mem_read = 1'($urandom); mem_write = 1'($urandom);
                    addr = $urandom; wdata = $urandom;
                end
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; addr = BASE; wdata = '0;
        step();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        step();
        rst = 1'b1; mem_read = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'd0 || rd_valid !== 1'b0 || addr_err !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h rv=%b err=%b stall=%b want 0/0/0/0",
                     rdata, rd_valid, addr_err, stall);
        end
        model_rdata = 32'd0;
    endtask

    task automatic test_fill();
        bit done, early, erv, eerr; int ns; logic rv, err; logic [31:0] rd;
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d;
            d = $urandom;
            model_access(0, 1, BASE + 32'(i * 4), d, erv, eerr);
            do_access(0, 1, BASE + 32'(i * 4), d, 0, done, ns, early, rv, err, rd);
            checks++;
            if (!done || ns != W + 1 || err !== 1'b0) begin
                errors++; $display("FAIL fill[%0d]: done=%b stall_cycles=%0d err=%b", i, done, ns, err);
            end
            step();
        end
    endtask

    task automatic test_directed(input string tag, input op_t ops[$]);
        bit done, early, erv, eerr; int ns; logic rv, err; logic [31:0] rd;
        foreach (ops[i]) begin
            model_access(ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, erv, eerr);
            do_access(ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, 0, done, ns, early, rv, err, rd);
            checks++;
            if (!done || ns != W + 1 || early) begin
                errors++;
                $display("FAIL %s[%0d] timing: done=%b stall_cycles=%0d early=%b want 1/%0d/0",
                         tag, i, done, ns, early, W + 1);
            end
            checks++;
            if (rv !== erv || err !== eerr || rd !== model_rdata) begin
                errors++;
                $display("FAIL %s[%0d] result: got rv=%b err=%b rdata=%h want %b/%b/%h",
                         tag, i, rv, err, rd, erv, eerr, model_rdata);
            end
            step();
        end
    endtask

    task automatic test_write_read();
        op_t ops[$];
        ops.push_back('{0, 1, 32'd1024, 32'hDEADBEEF});
        ops.push_back('{1, 0, 32'd1024, 32'h0});
        test_directed("write_read", ops);
    endtask

    task automatic test_addr_map();
        op_t ops[$];
        ops.push_back('{0, 1, 32'd1028, 32'h11});
        ops.push_back('{0, 1, 32'd1276, 32'h22});
        ops.push_back('{1, 0, 32'd1028, 32'h0});
        ops.push_back('{1, 0, 32'd1276, 32'h0});
        ops.push_back('{1, 0, 32'd1030, 32'h0});
        test_directed("addr_map", ops);
    endtask

    task automatic test_out_of_range();
        op_t ops[$];
        ops.push_back('{1, 0, 32'd1020, 32'h0});
        ops.push_back('{0, 1, 32'd1280, 32'hA5A5A5A5});
        ops.push_back('{1, 0, 32'd1280, 32'h0});
        ops.push_back('{0, 1, 32'd1023, 32'h5A5A5A5A});
        ops.push_back('{1, 0, 32'hFFFF_FFFC, 32'h0});
        ops.push_back('{1, 0, 32'd1024, 32'h0});
        test_directed("out_of_range", ops);
    endtask

    task automatic test_both_requests();
        op_t ops[$];
        ops.push_back('{1, 1, 32'd1024, 32'h7});
        ops.push_back('{1, 0, 32'd1024, 32'h0});
        test_directed("both_requests", ops);
    endtask

    task automatic test_mid_reset();
        bit done, early, erv, eerr; int ns; logic rv, err; logic [31:0] rd;
        logic [31:0] old;
        old = model[2];
        mem_write = 1'b1; mem_read = 1'b0; addr = 32'd1032; wdata = 32'h55;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL mid_reset_stall: got %b want 0", stall);
        end
        step();
        rst = 1'b1; mem_write = 1'b0;
        #1;
        model_rdata = 32'd0;
        checks++;
        if (stall !== 1'b0 || rdata !== 32'd0 || rd_valid !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: got stall=%b rdata=%h rv=%b err=%b want 0/0/0/0",
                     stall, rdata, rd_valid, addr_err);
        end
        step();
        model_access(1, 0, 32'd1032, 32'h0, erv, eerr);
        do_access(1, 0, 32'd1032, 32'h0, 0, done, ns, early, rv, err, rd);
        checks++;
        if (!done || ns != W + 1 || rd !== old || rv !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_store: got done=%b stall_cycles=%0d rdata=%h rv=%b err=%b want 1/%0d/%h/1/0",
                     done, ns, rd, rv, err, W + 1, old);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit done, early, erv, eerr; int ns; logic rv, err; logic [31:0] rd;
        int t0, t1, tdone;
        t0 = cyc;
        model_access(1, 0, 32'd1028, 32'h0, erv, eerr);
        do_access(1, 0, 32'd1028, 32'h0, 1, done, ns, early, rv, err, rd);
        checks++;
        if (!done || ns != W + 1 || rd !== model_rdata || rv !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got done=%b stall_cycles=%0d rdata=%h rv=%b want 1/%0d/%h/1",
                     done, ns, rd, rv, W + 1, model_rdata);
        end
        step();
        t1 = cyc;
        model_access(1, 0, 32'd1276, 32'h0, erv, eerr);
        do_access(1, 0, 32'd1276, 32'h0, 1, done, ns, early, rv, err, rd);
        tdone = cyc;
        checks++;
        if (!done || rd !== model_rdata || rv !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got done=%b rdata=%h rv=%b want 1/%h/1", done, rd, rv, model_rdata);
        end
        checks++;
        if (t1 - t0 != W + 2 || tdone - t0 != 2 * W + 3) begin
            errors++;
            $display("FAIL b2b_timing: got start=T0+%0d done=T0+%0d want T0+%0d/T0+%0d",
                     t1 - t0, tdone - t0, W + 2, 2 * W + 3);
        end
        step();
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 6; i++) begin
            addr = $urandom; wdata = $urandom; mem_read = 1'b0; mem_write = 1'b0;
            #1;
            checks++;
            if (stall !== 1'b0 || rd_valid !== 1'b0 || addr_err !== 1'b0 || rdata !== model_rdata) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got stall=%b rv=%b err=%b rdata=%h want 0/0/0/%h",
                         i, stall, rd_valid, addr_err, rdata, model_rdata);
            end
            step();
        end
    endtask

    task automatic test_random();
        bit done, early, erv, eerr; int ns; logic rv, err; logic [31:0] rd;
        for (int i = 0; i < 60; i++) begin
            bit r, w; logic [31:0] a, d; int unsigned k, sel;
            k = $urandom_range(0, 9);
            r = (k < 5) || (k == 9);
            w = (k >= 5);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       a = BASE - 32'd4;
                1:       a = BASE + 32'd256 + 32'($urandom_range(0, 3));
                2:       a = $urandom;
                default: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            endcase
            d = $urandom;
            model_access(r, w, a, d, erv, eerr);
            do_access(r, w, a, d, 2, done, ns, early, rv, err, rd);
            checks++;
            if (!done || ns != W + 1 || early || rv !== erv || err !== eerr || rd !== model_rdata) begin
                errors++;
                $display("FAIL random[%0d] rd=%b wr=%b a=%h: got done=%b ns=%0d early=%b rv=%b err=%b rdata=%h want 1/%0d/0/%b/%b/%h",
                         i, r, w, a, done, ns, early, rv, err, rd, W + 1, erv, eerr, model_rdata);
            end
            step();
            #1;
            checks++;
            if (rd_valid !== 1'b0 || addr_err !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL random_pulse[%0d]: got rv=%b err=%b stall=%b want 0/0/0",
                         i, rd_valid, addr_err, stall);
            end
        end
    endtask

    task automatic test_readback_all();
        bit done, early, erv, eerr; int ns; logic rv, err; logic [31:0] rd;
        for (int i = 0; i < DEPTH; i++) begin
            model_access(1, 0, BASE + 32'(i * 4), 32'h0, erv, eerr);
            do_access(1, 0, BASE + 32'(i * 4), 32'h0, 0, done, ns, early, rv, err, rd);
            checks++;
            if (!done || rd !== model_rdata || rv !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL readback[%0d]: got done=%b rdata=%h rv=%b err=%b want 1/%h/1/0",
                         i, done, rd, rv, err, model_rdata);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_addr_map();
        test_out_of_range();
        test_mid_reset();
        test_back_to_back();
        test_both_requests();
        test_idle_hold();
        test_random();
        test_readback_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
